// File: rtl/gray_step_checker.sv
// Registers Gray-coded samples, converts them to binary and checks that every
// accepted step is a single legal increment, with lock tracking and error/wrap counters.
module gray_step_checker #(
  parameter int CBITS  = 18,
  parameter int LOCK_N = 4,
  parameter int WBITS  = 16,
  parameter int ECBITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CBITS-1:0]  gray_in,
  input  logic              sig_in,
  input  logic              valid_in,
  input  logic              clr_err,
  output logic [CBITS-1:0]  bin_out,
  output logic              bin_valid,
  output logic              step_err,
  output logic              sig_err,
  output logic              locked,
  output logic [WBITS-1:0]  wrap_cnt,
  output logic [ECBITS-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0]        LOCK_TGT = 4'(LOCK_N);
  localparam logic [CBITS-1:0]  ZERO_C   = {CBITS{1'b0}};
  localparam logic [CBITS-1:0]  ONE_C    = {{(CBITS-1){1'b0}}, 1'b1};
  localparam logic [ECBITS-1:0] ZERO_E   = {ECBITS{1'b0}};
  localparam logic [ECBITS-1:0] ONE_E    = {{(ECBITS-1){1'b0}}, 1'b1};

  function automatic logic [CBITS-1:0] gray2bin(input logic [CBITS-1:0] g);
    logic [CBITS-1:0] b;
    b[CBITS-1] = g[CBITS-1];
    for (int i = CBITS - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic single_bit(input logic [CBITS-1:0] v);
    return (v != ZERO_C) && ((v & (v - ONE_C)) == ZERO_C);
  endfunction

  state_t            state_r, state_nx_s;
  logic [3:0]        lock_cnt_r, lock_nx_s;
  logic [CBITS-1:0]  ref_r;
  logic [CBITS-1:0]  bin_s, inc_s;
  logic              good_s, sig_bad_s, step_err_nx_s, wrap_inc_s, err_any_s;
  logic [ECBITS-1:0] err_base_s, err_nx_s;

  // Step qualification: one bit flipped and the binary value advanced by exactly one.
  always_comb begin
    bin_s     = gray2bin(gray_in);
    inc_s     = bin_out + ONE_C;
    good_s    = single_bit(gray_in ^ ref_r) && (bin_s == inc_s);
    sig_bad_s = sig_in ^ (gray_in == ZERO_C);
  end

  // Lock state machine next-state and step/wrap decisions.
  always_comb begin
    state_nx_s    = state_r;
    lock_nx_s     = lock_cnt_r;
    step_err_nx_s = 1'b0;
    wrap_inc_s    = 1'b0;
    if (valid_in) begin
      case (state_r)
        IDLE: begin
          lock_nx_s  = 4'd0;
          state_nx_s = ACQ;
        end
        ACQ: begin
          if (good_s) begin
            lock_nx_s = lock_cnt_r + 4'd1;
            if (lock_cnt_r + 4'd1 == LOCK_TGT) begin
              state_nx_s = LOCKED;
            end else begin
              state_nx_s = ACQ;
            end
          end else begin
            lock_nx_s  = 4'd0;
            state_nx_s = ACQ;
          end
        end
        LOCKED: begin
          if (good_s) begin
            wrap_inc_s = (gray_in == ZERO_C);
          end else begin
            step_err_nx_s = 1'b1;
            lock_nx_s     = 4'd0;
            state_nx_s    = ACQ;
          end
        end
        default: begin
          lock_nx_s  = 4'd0;
          state_nx_s = IDLE;
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // Error counter: clear first, then count this cycle's error, saturating at all-ones.
  always_comb begin
    err_any_s = valid_in & (step_err_nx_s | sig_bad_s);
    if (clr_err) begin
      err_base_s = ZERO_E;
    end else begin
      err_base_s = err_cnt;
    end
    if (err_any_s && !(&err_base_s)) begin
      err_nx_s = err_base_s + ONE_E;
    end else begin
      err_nx_s = err_base_s;
    end
  end

  // State, reference and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      lock_cnt_r <= 4'd0;
      ref_r      <= ZERO_C;
      bin_out    <= ZERO_C;
      bin_valid  <= 1'b0;
      step_err   <= 1'b0;
      sig_err    <= 1'b0;
      locked     <= 1'b0;
      wrap_cnt   <= {WBITS{1'b0}};
      err_cnt    <= ZERO_E;
    end else begin
      bin_valid <= valid_in;
      step_err  <= step_err_nx_s;
      sig_err   <= valid_in & sig_bad_s;
      err_cnt   <= err_nx_s;
      if (valid_in) begin
        state_r    <= state_nx_s;
        lock_cnt_r <= lock_nx_s;
        ref_r      <= gray_in;
        bin_out    <= bin_s;
        locked     <= (state_nx_s == LOCKED);
        wrap_cnt   <= wrap_cnt + {{(WBITS-1){1'b0}}, wrap_inc_s};
      end
    end
  end

endmodule

// File: tb/tb_gray_step_checker.sv
// Self-checking bench for gray_step_checker: directed scenarios plus a randomized
// stream, all compared against an integer-arithmetic reference model.
module tb_gray_step_checker;

  localparam int CB = 4;
  localparam int WB = 4;
  localparam int EB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CB-1:0] gray_in = '0;
  logic          sig_in = 1'b0;
  logic          valid_in = 1'b0;
  logic          clr_err = 1'b0;
  logic [CB-1:0] bin_out;
  logic          bin_valid, step_err, sig_err, locked;
  logic [WB-1:0] wrap_cnt;
  logic [EB-1:0] err_cnt;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit m_have_ref, m_lock, m_bv, m_se, m_ze;
  int m_prev, m_run, m_wrap, m_err, m_bin;

  gray_step_checker #(.CBITS(CB), .LOCK_N(4), .WBITS(WB), .ECBITS(EB)) dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .sig_in(sig_in), .valid_in(valid_in),
    .clr_err(clr_err), .bin_out(bin_out), .bin_valid(bin_valid), .step_err(step_err),
    .sig_err(sig_err), .locked(locked), .wrap_cnt(wrap_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) % 16;
  endfunction

  function automatic int from_gray(input int g);
    int b = g;
    for (int s = g >> 1; s != 0; s = s >> 1) b = b ^ s;
    return b;
  endfunction

  function automatic logic [15:0] dut_vec();
    return {bin_out, bin_valid, step_err, sig_err, locked, wrap_cnt, err_cnt};
  endfunction

  function automatic logic [15:0] model_vec();
    return {4'(m_bin), m_bv, m_se, m_ze, m_lock, 4'(m_wrap), 4'(m_err)};
  endfunction

  task automatic model_reset();
    m_have_ref = 0; m_lock = 0; m_bv = 0; m_se = 0; m_ze = 0;
    m_prev = 0; m_run = 0; m_wrap = 0; m_err = 0; m_bin = 0;
  endtask

  task automatic model_step(input bit v, input int g, input bit s, input bit c);
    int b;
    bit good;
    m_bv = v; m_se = 0; m_ze = 0;
    if (v) begin
      b    = from_gray(g);
      good = (b == (m_prev + 1) % 16);
      m_ze = (s != (g == 0));
      if (!m_have_ref) begin
        m_have_ref = 1; m_run = 0;
      end else if (m_lock) begin
        if (good) begin
          if (g == 0) m_wrap = (m_wrap + 1) % 16;
        end else begin
          m_se = 1; m_lock = 0; m_run = 0;
        end
      end else if (good) begin
        m_run++;
        if (m_run == 4) m_lock = 1;
      end else begin
        m_run = 0;
      end
      m_prev = b;
      m_bin  = b;
    end
    if (c) m_err = 0;
    if ((m_se || m_ze) && m_err < 15) m_err++;
  endtask

  // Drive one cycle from a negedge; returns at the following negedge.
  task automatic step(input bit v, input int g, input bit s, input bit c);
    valid_in = v; gray_in = 4'(g); sig_in = s; clr_err = c;
    @(posedge clk);
    model_step(v, g, s, c);
    @(negedge clk);
  endtask

  task automatic feed_bin(input int b, input bit wrong_sig);
    int g = to_gray(b);
    step(1'b1, g, (g == 0) ^ wrong_sig, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    model_reset();
    checks++;
    if (dut_vec() !== 16'h0) begin
      failures++; $display("FAIL reset: got %h want %h", dut_vec(), 16'h0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean_start();
    int seq[5] = '{0, 1, 3, 2, 6};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq[i], i == 0, 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL clean_start[%0d]: got %h want %h", i, dut_vec(), model_vec());
      end
      checks++;
      if (bin_out !== 4'(i)) begin
        failures++; $display("FAIL clean_bin[%0d]: got %0d want %0d", i, bin_out, i);
      end
    end
    checks++;
    if (locked !== 1'b1) begin
      failures++; $display("FAIL clean_locked: got %b want 1", locked);
    end
  endtask

  task automatic test_wrap();
    for (int b = 5; b <= 16; b++) begin
      feed_bin(b % 16, 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL wrap[%0d]: got %h want %h", b, dut_vec(), model_vec());
      end
    end
    checks++;
    if ({wrap_cnt, step_err, sig_err, locked} !== {4'd1, 1'b0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL wrap_cnt: got %0d/%b%b%b want 1/001", wrap_cnt, step_err, sig_err, locked);
    end
  endtask

  task automatic test_jump();
    for (int b = 1; b <= 5; b++) feed_bin(b, 1'b0);
    feed_bin(8, 1'b0);
    checks++;
    if ({step_err, locked, err_cnt} !== {1'b1, 1'b0, 4'd1} || dut_vec() !== model_vec()) begin
      failures++; $display("FAIL jump: got %h want %h", dut_vec(), model_vec());
    end
    for (int b = 9; b <= 12; b++) begin
      feed_bin(b, 1'b0);
      checks++;
      if (dut_vec() !== model_vec() || locked !== (b == 12)) begin
        failures++; $display("FAIL relock[%0d]: got %h want %h", b, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_flag();
    feed_bin(13, 1'b1);
    checks++;
    if ({sig_err, step_err, locked, err_cnt} !== {1'b1, 1'b0, 1'b1, 4'd2} || dut_vec() !== model_vec()) begin
      failures++; $display("FAIL flag: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_gaps();
    feed_bin(14, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, $urandom_range(15), $urandom_range(1), 1'b0);
      checks++;
      if (bin_valid !== 1'b0 || dut_vec() !== model_vec()) begin
        failures++; $display("FAIL gap[%0d]: got %h want %h", i, dut_vec(), model_vec());
      end
    end
    feed_bin(15, 1'b0);
    checks++;
    if ({bin_out, bin_valid, step_err, sig_err, locked} !== {4'd15, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL gap_resume: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_clear_and_reset();
    for (int b = 0; b < 3; b++) feed_bin(b, 1'b1);
    checks++;
    if (err_cnt !== 4'd5) begin
      failures++; $display("FAIL err_five: got %0d want 5", err_cnt);
    end
    step(1'b1, to_gray(9), 1'b0, 1'b1);
    checks++;
    if ({step_err, err_cnt} !== {1'b1, 4'd1} || dut_vec() !== model_vec()) begin
      failures++; $display("FAIL clr_with_err: got %h want %h", dut_vec(), model_vec());
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== 16'h0) begin
      failures++; $display("FAIL midcycle_reset: got %h want 0", dut_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    feed_bin(7, 1'b0);
    checks++;
    if ({step_err, locked, bin_out} !== {1'b0, 1'b0, 4'd7} || dut_vec() !== model_vec()) begin
      failures++; $display("FAIL reseed: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_random();
    int cur = 7;
    int nxt, r, g;
    bit v, c;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom % 5) != 0;
      r = $urandom % 10;
      if (r < 7) nxt = (cur + 1) % 16;
      else if (r == 7) nxt = cur;
      else if (r == 8) nxt = $urandom % 16;
      else nxt = (cur + 2) % 16;
      g = to_gray(nxt);
      c = v && (($urandom % 25) == 0);
      step(v, g, (g == 0) ^ (($urandom % 12) == 0), c);
      if (v) cur = nxt;
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_clean_start();
    test_wrap();
    test_jump();
    test_flag();
    test_gaps();
    test_clear_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_step_checker.md
# gray_step_checker

Downstream consumer of the free-running Gray counter's `gray_cnt`/`sig` outputs, in the same clock domain. It registers each sample, converts it back to binary, and checks that every step is a legal single increment. It also checks that the zero-detect flag agrees with the code, and counts genuine wrap-arounds. A small lock state machine decides when step errors are reported, so that start-up and upstream resets do not raise spurious errors.

## Interface

Parameters:
- `CBITS`, 18 — Gray code width; must match the upstream counter.
- `LOCK_N`, 4 — consecutive good steps required to reach LOCKED (1..15).
- `WBITS`, 16 — wrap counter width.
- `ECBITS`, 8 — error counter width.

Ports:
- `clk` in 1 — clock.
- `rst` in 1 — reset, asynchronous, active-high.
- `gray_in` in CBITS — Gray code sample (upstream `gray_cnt`).
- `sig_in` in 1 — upstream zero flag (upstream `sig`).
- `valid_in` in 1 — sample qualifier; tie high when upstream updates every cycle.
- `clr_err` in 1 — synchronous clear of `err_cnt`.
- `bin_out` out CBITS — binary value of the last valid sample.
- `bin_valid` out 1 — one-cycle strobe: `bin_out` was updated at this edge.
- `step_err` out 1 — one-cycle pulse: illegal step detected while LOCKED.
- `sig_err` out 1 — one-cycle pulse: `sig_in` != (`gray_in` == 0).
- `locked` out 1 — state == LOCKED.
- `wrap_cnt` out WBITS — count of legal max→0 wraps.
- `err_cnt` out ECBITS — saturating count of cycles with any error pulse.

## Operation

- **Sample acceptance.** A sample is accepted at a rising edge with `valid_in`=1. With `valid_in`=0, all registers hold and the pulse outputs are 0.
- **Gaps.** Gaps are transparent: the next accepted sample is compared against the last accepted sample.
- **Conversion.** `b[CBITS-1]` = `g[CBITS-1]`; `b[i]` = `b[i+1]` ^ `g[i]`. The result is combinational on `gray_in` and registered into `bin_out`.
- **Good step.** A step is good when both hold:
  - Hamming distance between `gray_in` and the previous sample is exactly 1.
  - `b_new` == (`b_prev` + 1) mod 2^CBITS.
  - Any other step is bad, including a repeated value.
- **State machine** (`lock_cnt` counts good steps):
  - **IDLE** (reset state). First accepted sample is stored as reference, `lock_cnt`=0, next state ACQ. No step check in IDLE.
  - **ACQ.** Good step: `lock_cnt`++; when it reaches LOCK_N, go to LOCKED. Bad step: `lock_cnt`=0, stay in ACQ, no `step_err`.
  - **LOCKED.** Good step: stay. Bad step: `step_err`=1, go to ACQ with `lock_cnt`=0. The bad sample becomes the new reference.
- **Zero-flag check.** `sig_err` is evaluated on every accepted sample in all states, including IDLE. It never affects state.
- **Wrap counting.** `wrap_cnt` increments, modulo 2^WBITS, when all of the following hold:
  - the sample is accepted in LOCKED;
  - the step is good;
  - `gray_in` == 0.
- **Error counting.** `err_cnt` increments by 1 in a cycle where `step_err` | `sig_err` (both together count as 1). It saturates at all-ones.
- **Error clear.** `clr_err` zeroes `err_cnt`. If it coincides with an error cycle, the result is 1: clear is applied first, then the new error is counted.

## Timing

- **Latency.** All outputs are registered. A sample accepted at edge k produces `bin_out`, `bin_valid`, `step_err`, `sig_err`, `locked`, `wrap_cnt` and `err_cnt` updates visible immediately after edge k, i.e. one cycle of latency from input to output.
- **Lock time.** `locked` rises after the edge accepting the (LOCK_N+1)-th consecutive sample of a clean sequence (IDLE sample plus LOCK_N good steps).
- **Reset.** `rst` clears the following immediately, regardless of `clk`:
  - state=IDLE, `lock_cnt`=0, stored reference=0;
  - outputs `bin_out`=0, `bin_valid`=0, `step_err`=0, `sig_err`=0, `locked`=0, `wrap_cnt`=0, `err_cnt`=0.
- **Reset mid-lock.** Same clearing as above. The first sample after release only re-seeds the reference.
- **Upstream reset.** If the upstream counter is reset while this block is LOCKED, one `step_err` is expected, followed by relock within LOCK_N good steps.

## Test plan

All directed tests use CBITS=4, LOCK_N=4.

1. **Clean start.** After reset, feed `gray_in` 0000, 0001, 0011, 0010, 0110, with `valid_in`=1 and `sig_in`=1 only on the first sample.
   - `bin_out` reads 0, 1, 2, 3, 4.
   - `locked` is 1 after the 5th edge; no error pulses.
2. **Wrap.** While LOCKED, feed bin 14, 15, 0 (gray 1001, 1000, 0000), with `sig_in`=1 on the 0 sample.
   - `wrap_cnt` goes 0→1; `step_err`=0, `sig_err`=0.
3. **Jump.** While LOCKED at bin 5 (gray 0111), feed gray 1100 (bin 8).
   - `step_err` pulses for 1 cycle, `err_cnt`=1, `locked`=0.
   - Continue 9, 10, 11, 12: `locked` returns to 1 after the 4th good step.
4. **Flag mismatch.** While LOCKED, feed gray 0011 (legal next step) with `sig_in`=1.
   - `sig_err` pulses once, `err_cnt` increments by 1, `locked` stays 1, `step_err`=0.
5. **Gaps.** While LOCKED, accept bin 3, then hold `valid_in`=0 for 3 cycles, then accept bin 4.
   - No error pulses, `locked` stays 1, `bin_valid` is 0 during the gap.
6. **Clear and reset.**
   - Set `err_cnt`=5 with errors, then assert `clr_err` in the same cycle as a `step_err`: `err_cnt`=1.
   - Then pulse `rst` mid-cycle: every output is 0 before the next edge.
